// File: rtl/alaw_pkg.sv
// Shared definitions for the A-law PCM serializer slice.
// Provides the codeword width, the G.711 even-bit inversion mask, the
// default idle codeword and the framing state encoding.
package alaw_pkg;
  localparam int         ALAW_W            = 8;
  localparam logic [7:0] ALAW_INV_MASK     = 8'h55;
  localparam logic [7:0] ALAW_IDLE_DEFAULT = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_SLOT, S_GAP} state_e;
endpackage

// File: rtl/alaw_pcm_serializer_if.sv
// Codeword handshake between the A-law coder (master) and the serializer
// (slave).
//   in_alaw  : 8-bit A-law codeword
//   in_valid : codeword valid
//   in_ready : serializer FIFO can accept
interface alaw_pcm_serializer_if;
  import alaw_pkg::*;
  logic [ALAW_W-1:0] in_alaw;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_alaw, in_valid, input  in_ready);
  modport slave  (input  in_alaw, in_valid, output in_ready);
endinterface

// File: rtl/alaw_sync_fifo.sv
// Small synchronous FIFO with synchronous active-low reset.
//   push/wr_data : write when not full (refused otherwise)
//   pop/rd_data  : read when not empty; rd_data shows the head word
//   full/empty   : derived from registered occupancy only
//   level        : current occupancy
module alaw_sync_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full is checked before any pop of this cycle, so a full FIFO refuses
  // a push even when a word leaves in the same clock.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/alaw_pcm_serializer.sv
// A-law PCM serializer: buffers codewords from the coder and shifts each
// out MSB-first as the first 8 bits of a FRAME_LEN-bit PCM frame, with a
// frame-sync pulse on bit 0. Sends IDLE_CODE when the FIFO is empty at
// frame start. Paced by the bit_en strobe; outputs hold between strobes.
// Optional build macro ALAW_EVEN_BIT_INVERT_EN: XOR each loaded word
// (including the idle code) with 8'h55 before shifting.
// Ports:
//   clk, rst_n   : system clock, synchronous active-low reset
//   bit_en       : one-clk strobe per serial bit period
//   in_if        : codeword handshake (slave side)
//   sdo, fsync   : registered serial data and frame sync
//   fifo_level   : FIFO occupancy
//   underrun_cnt : saturating count of idle-code insertions
module alaw_pcm_serializer
  import alaw_pkg::*;
#(
  parameter  int         FIFO_DEPTH = 4,
  parameter  int         FRAME_LEN  = 32,
  parameter  logic [7:0] IDLE_CODE  = ALAW_IDLE_DEFAULT,
  localparam int         LW         = $clog2(FIFO_DEPTH) + 1,
  localparam int         CW         = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_en,
  alaw_pcm_serializer_if.slave  in_if,
  output logic                  sdo,
  output logic                  fsync,
  output logic [LW-1:0]         fifo_level,
  output logic [7:0]            underrun_cnt
);
  state_e            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ALAW_W-1:0] shreg_q, shreg_d;
  logic              sdo_q, sdo_d, fsync_q, fsync_d;
  logic [7:0]        urun_q, urun_d;

  logic              full, empty, frame_start, pop;
  logic [ALAW_W-1:0] head, load_word;

  alaw_sync_fifo #(.W(ALAW_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_if.in_valid),
    .wr_data (in_if.in_alaw),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign in_if.in_ready = !full;
  assign sdo            = sdo_q;
  assign fsync          = fsync_q;
  assign underrun_cnt   = urun_q;

  assign frame_start = bit_en && ((state_q == S_IDLE) ||
                       (state_q == S_GAP && bit_cnt_q == CW'(FRAME_LEN - 1)));
  // Uses registered empty, so a word pushed in this very cycle waits for
  // the next frame.
  assign pop = frame_start && !empty;

`ifdef ALAW_EVEN_BIT_INVERT_EN
  assign load_word = (empty ? IDLE_CODE : head) ^ ALAW_INV_MASK;
`else
  assign load_word = empty ? IDLE_CODE : head;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sdo_d     = sdo_q;
    fsync_d   = fsync_q;
    urun_d    = urun_q;
    if (frame_start) begin
      shreg_d   = load_word;
      sdo_d     = load_word[ALAW_W-1];
      fsync_d   = 1'b1;
      bit_cnt_d = '0;
      state_d   = S_SLOT;
      if (empty && urun_q != 8'hFF) urun_d = urun_q + 8'd1;
    end else if (bit_en) begin
      case (state_q)
        S_SLOT: begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          fsync_d   = 1'b0;
          shreg_d   = {shreg_q[ALAW_W-2:0], 1'b0};
          if (bit_cnt_d == CW'(ALAW_W)) begin
            state_d = S_GAP;
            sdo_d   = 1'b0;
          end else begin
            sdo_d   = shreg_d[ALAW_W-1];
          end
        end
        S_GAP: begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          sdo_d     = 1'b0;
          fsync_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sdo_q     <= 1'b0;
      fsync_q   <= 1'b0;
      urun_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sdo_q     <= sdo_d;
      fsync_q   <= fsync_d;
      urun_q    <= urun_d;
    end
  end
endmodule

// File: doc/alaw_pcm_serializer.md
Name: alaw_pcm_serializer

Overview:
- Downstream stage of the A-law coder. Accepts 8-bit A-law codewords over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each codeword out MSB-first as one timeslot of a PCM serial frame, with a frame-sync pulse.
- Paced by a bit-rate strobe from the system clock divider. Inserts an idle codeword when the FIFO underruns.

Parameters:
- FIFO_DEPTH, 4, number of buffered codewords; power of two, >= 2.
- FRAME_LEN, 32, bit periods per frame; >= 9.
- IDLE_CODE, 8'h80, codeword sent on underrun (A-law +0 before line inversion).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- bit_en  in  1  one-clk strobe, one per serial bit period
- in_alaw  in  8  A-law codeword from the coder
- in_valid  in  1  in_alaw valid
- in_ready  out  1  FIFO can accept (= !full)
- sdo  out  1  serial data, registered
- fsync  out  1  frame sync, high during bit period 0, registered
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
- underrun_cnt  out  8  saturating count of idle-code insertions

Behaviour:
- Reset (rst_n low at a clk edge) clears the FIFO and sets:
  - sdo=0, fsync=0, fifo_level=0, underrun_cnt=0, in_ready=1
  - shift register=0, bit_cnt=0, state=S_IDLE
  - Reset mid-frame discards the partial frame and all buffered words.
- Push: in_valid && in_ready at a clk edge writes in_alaw.
  - in_ready is derived from registered occupancy only. When full, a push is refused even if a pop occurs in the same cycle.
- Pop happens only on frame-start bit_en cycles. A push into an empty FIFO in the same cycle as a pop is not visible to that pop: the idle code is sent and the pushed word is kept for the next frame.
- fifo_level updates on the clk edge after a push/pop. Simultaneous push+pop leaves it unchanged.
- State machine; all transitions occur only on clk edges where bit_en=1. Outputs hold between strobes.
  - S_IDLE: sdo=0, fsync=0. On bit_en: frame start.
  - Frame start:
    - If the FIFO is non-empty, pop the word into the shift register; otherwise load IDLE_CODE and increment underrun_cnt (saturates at 255).
    - Set sdo=word[7], fsync=1, bit_cnt=0, state=S_SLOT.
  - S_SLOT, on bit_en: bit_cnt+1.
    - For bit_cnt 1..7: sdo=word[7-bit_cnt], fsync=0.
    - When bit_cnt reaches 8: state=S_GAP, sdo=0.
  - S_GAP, on bit_en: bit_cnt+1, sdo=0, fsync=0.
    - When the current bit_cnt==FRAME_LEN-1, the next strobe performs a frame start instead (bit_cnt wraps to 0).
- Latency: the first strobe after reset starts frame 0. A word pushed before that strobe appears on sdo in the same clk edge as fsync.
- The bit period is the interval between strobes. bit_en held high every clk is legal: one bit per clk.
- bit_cnt width is clog2(FRAME_LEN). Wrap is explicit at FRAME_LEN-1, never natural overflow.

Optional Feature:
- Macro: ALAW_EVEN_BIT_INVERT_EN.
- Defined: the loaded word is XORed with 8'h55 (G.711 even-bit inversion) before shifting. IDLE_CODE is also inverted, so 8'h80 goes out as 8'hD5.
- Undefined: words are shifted unmodified.
- FIFO contents and underrun_cnt are unaffected either way.

Decomposition:
- Shared package alaw_pkg:
  - state enum (S_IDLE, S_SLOT, S_GAP)
  - ALAW_W=8
  - ALAW_INV_MASK=8'h55
  - ALAW_IDLE_DEFAULT=8'h80
- Sub-module alaw_sync_fifo: parameterised width/depth, synchronous active-low reset, push/pop/full/empty/level. The serializer owns the framing FSM and shift register.

Test Plan:
- Reset, push 8'hA5, bit_en every 4 clk -> first frame: fsync high for 1 bit period, sdo=1,0,1,0,0,1,0,1, then 24 zeros; next frame carries idle 8'h80 and underrun_cnt=1.
- Push 8'h11,8'h22,8'h33,8'h44 with no bit_en -> fifo_level=4, in_ready=0. A 5th push is refused. The frames then send 11,22,33,44 in order.
- FIFO full, push asserted on the frame-start pop cycle -> push refused, fifo_level goes 4->3. Empty FIFO, push on the pop cycle -> idle code sent, fifo_level=1 afterwards.
- No pushes for 300 frames -> underrun_cnt saturates at 255; sdo always carries IDLE_CODE.
- Assert rst_n low at bit 3 of a slot with 2 words buffered -> the next cycle shows sdo=0, fsync=0, fifo_level=0, state S_IDLE; the old words are never transmitted.
- With ALAW_EVEN_BIT_INVERT_EN: push 8'h00 -> line shows 8'h55; underrun frame shows 8'hD5.
